// File: rtl/cipher_sequencer_if.sv
//------------------------------------------------------------------------------
// Module   : cipher_sequencer_if
// Purpose  : Keyboard, cipher-datapath, VGA and status bundle of the sequencer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface cipher_sequencer_if #(
   parameter int AW = 4
);
   logic          kb_ready;
   logic [7:0]    kb_ascii;
   logic          enter_n;
   logic          key_load;
   logic [7:0]    key_char;
   logic          enc_valid;
   logic [7:0]    enc_char;
   logic          enc_ready;
   logic          res_valid;
   logic [7:0]    res_char;
   logic          vga_go;
   logic [7:0]    vga_char;
   logic          vga_busy;
   logic [2:0]    state;
   logic [AW:0]   count;
   logic          overflow;

   // The sequencer drives requests and status; the environment answers.
   modport master (
      input  kb_ready, kb_ascii, enter_n, enc_ready, res_valid, res_char, vga_busy,
      output key_load, key_char, enc_valid, enc_char, vga_go, vga_char,
             state, count, overflow
   );

   modport slave (
      output kb_ready, kb_ascii, enter_n, enc_ready, res_valid, res_char, vga_busy,
      input  key_load, key_char, enc_valid, enc_char, vga_go, vga_char,
             state, count, overflow
   );
endinterface

`default_nettype wire

// File: rtl/cipher_sequencer.sv
//------------------------------------------------------------------------------
// Module   : cipher_sequencer
// Purpose  : Captures key and message, streams it through the cipher, shows it.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cipher_sequencer #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic               clk,
   input  logic               resetn,
   cipher_sequencer_if.master bus
);

   localparam logic [2:0] c_S_IDLE       = 3'd0;
   localparam logic [2:0] c_S_KEY        = 3'd1;
   localparam logic [2:0] c_S_MSG        = 3'd2;
   localparam logic [2:0] c_S_ENC        = 3'd3;
   localparam logic [2:0] c_S_SHOW       = 3'd4;
   localparam logic [2:0] c_S_DONE       = 3'd5;
   localparam logic [1:0] c_SUB_ISSUE    = 2'd0;
   localparam logic [1:0] c_SUB_WAIT     = 2'd1;
   localparam logic [1:0] c_SUB_GO       = 2'd0;
   localparam logic [1:0] c_SUB_HOLD     = 2'd1;
   localparam logic [1:0] c_SUB_IDLEWAIT = 2'd2;
   localparam logic [AW:0]   c_FULL    = (AW+1)'(DEPTH);
   localparam logic [AW:0]   c_CNT_ONE = 1;
   localparam logic [AW-1:0] c_IDX_ONE = 1;

   logic [2:0]    r_state;
   logic [1:0]    r_sub;
   logic [AW-1:0] r_idx;
   logic [AW:0]   r_count;
   logic          r_overflow;
   logic          r_key_load;
   logic [7:0]    r_key_char;
   logic          r_enc_valid;
   logic [7:0]    r_enc_char;
   logic          r_vga_go;
   logic [7:0]    r_vga_char;
   logic          r_enter_s1, r_enter_s2, r_enter_s3, r_enter_evt;
   logic          r_kb_valid;
   logic [7:0]    r_kb_char;
   logic [7:0]    r_buf [DEPTH];

   logic          w_store, w_drop, w_last, w_res_take, w_buf_we;
   logic [AW:0]   w_count_nxt;
   logic [AW-1:0] w_buf_addr;
   logic [7:0]    w_buf_wdata;

   always_comb begin
      w_store     = (r_state == c_S_MSG) && r_kb_valid && (r_count != c_FULL);
      w_drop      = (r_state == c_S_MSG) && r_kb_valid && (r_count == c_FULL);
      w_count_nxt = w_store ? (r_count + c_CNT_ONE) : r_count;
      w_last      = ({1'b0, r_idx} == (r_count - c_CNT_ONE));
      w_res_take  = (r_state == c_S_ENC) && (r_sub == c_SUB_WAIT) && bus.res_valid;
      w_buf_we    = w_store || w_res_take;
      w_buf_addr  = w_store ? r_count[AW-1:0] : r_idx;
      w_buf_wdata = w_store ? r_kb_char : bus.res_char;
   end

   // Message storage carries no reset; r_count alone marks valid entries.
   always_ff @(posedge clk) begin
      if (w_buf_we) r_buf[w_buf_addr] <= w_buf_wdata;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= c_S_IDLE;
         r_sub       <= 2'd0;
         r_idx       <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_key_load  <= 1'b0;
         r_key_char  <= 8'h00;
         r_enc_valid <= 1'b0;
         r_enc_char  <= 8'h00;
         r_vga_go    <= 1'b0;
         r_vga_char  <= 8'h00;
         r_enter_s1  <= 1'b1;
         r_enter_s2  <= 1'b1;
         r_enter_s3  <= 1'b1;
         r_enter_evt <= 1'b0;
         r_kb_valid  <= 1'b0;
         r_kb_char   <= 8'h00;
      end else begin
         r_enter_s1  <= bus.enter_n;
         r_enter_s2  <= r_enter_s1;
         r_enter_s3  <= r_enter_s2;
         r_enter_evt <= r_enter_s3 & ~r_enter_s2;
         r_kb_valid  <= bus.kb_ready && (bus.kb_ascii != 8'h00);
         r_kb_char   <= bus.kb_ascii;
         r_key_load  <= 1'b0;
         r_vga_go    <= 1'b0;
         case (r_state)
            c_S_IDLE: if (r_enter_evt) r_state <= c_S_KEY;
            c_S_KEY: begin
               if (r_kb_valid) begin
                  r_key_char <= r_kb_char;
                  r_key_load <= 1'b1;
                  r_state    <= c_S_MSG;
               end
            end
            c_S_MSG: begin
               // A keystroke in the enter cycle counts toward the empty check.
               r_count <= w_count_nxt;
               if (w_drop) r_overflow <= 1'b1;
               if (r_enter_evt) begin
                  r_state <= (w_count_nxt != '0) ? c_S_ENC : c_S_DONE;
                  r_sub   <= c_SUB_ISSUE;
                  r_idx   <= '0;
               end
            end
            c_S_ENC: begin
               if (r_sub == c_SUB_ISSUE) begin
                  if (!r_enc_valid) begin
                     r_enc_valid <= 1'b1;
                     r_enc_char  <= r_buf[r_idx];
                  end else if (bus.enc_ready) begin
                     r_enc_valid <= 1'b0;
                     r_sub       <= c_SUB_WAIT;
                  end
               end else if (bus.res_valid) begin
                  if (w_last) begin
                     r_state <= c_S_SHOW;
                     r_sub   <= c_SUB_GO;
                     r_idx   <= '0;
                  end else begin
                     r_idx <= r_idx + c_IDX_ONE;
                     r_sub <= c_SUB_ISSUE;
                  end
               end
            end
            c_S_SHOW: begin
               case (r_sub)
                  c_SUB_GO: begin
                     if (!bus.vga_busy) begin
                        r_vga_go   <= 1'b1;
                        r_vga_char <= r_buf[r_idx];
                        r_sub      <= c_SUB_HOLD;
                     end
                  end
                  c_SUB_HOLD: r_sub <= c_SUB_IDLEWAIT;
                  default: begin
                     if (!bus.vga_busy) begin
                        if (w_last) begin
                           r_state <= c_S_DONE;
                           r_idx   <= '0;
                        end else begin
                           r_idx <= r_idx + c_IDX_ONE;
                        end
                        r_sub <= c_SUB_GO;
                     end
                  end
               endcase
            end
            c_S_DONE: begin
               if (r_enter_evt) begin
                  r_state    <= c_S_IDLE;
                  r_count    <= '0;
                  r_overflow <= 1'b0;
               end
            end
            default: r_state <= c_S_IDLE;
         endcase
      end
   end

   assign bus.key_load  = r_key_load;
   assign bus.key_char  = r_key_char;
   assign bus.enc_valid = r_enc_valid;
   assign bus.enc_char  = r_enc_char;
   assign bus.vga_go    = r_vga_go;
   assign bus.vga_char  = r_vga_char;
   assign bus.state     = r_state;
   assign bus.count     = r_count;
   assign bus.overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_cipher_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_cipher_sequencer
// Purpose  : Scenario bench for cipher_sequencer with datapath and VGA models.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_cipher_sequencer;

   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam logic [2:0] S_IDLE = 3'd0, S_KEY = 3'd1, S_MSG = 3'd2,
                          S_ENC = 3'd3, S_SHOW = 3'd4, S_DONE = 3'd5;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   cipher_sequencer_if #(.AW(AW)) bus ();
   cipher_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .resetn(resetn), .bus(bus));

   int n_vec = 0, n_err = 0;
   logic [7:0] stim_q[$], exp_buf[$], enc_q[$], vga_q[$], key_q[$];
   bit  exp_ovf;
   bit  dp_stall = 0, vga_hold = 0, rand_ready = 0;
   int  clr_id = 0, clr_seen = 0;
   int  lat = 0, busy_cnt = 0, go_gap = 100, gap_viol = 0;
   int  enc_valid_cycles = 0, enc_state_cycles = 0;
   logic [7:0] res_hold;

   // Datapath (char+1, 2-cycle latency), VGA writer (busy 4 cycles) and monitors.
   always @(negedge clk) begin
      if (clr_id != clr_seen) begin
         clr_seen = clr_id;
         key_q.delete(); enc_q.delete(); vga_q.delete();
         enc_valid_cycles = 0; enc_state_cycles = 0; gap_viol = 0; go_gap = 100;
      end
      if (!resetn) begin
         lat = 0; busy_cnt = 0;
         bus.res_valid = 1'b0; bus.res_char = 8'h00;
         bus.enc_ready = 1'b0; bus.vga_busy = 1'b0;
      end else begin
         if (bus.key_load) key_q.push_back(bus.key_char);
         if (bus.enc_valid) enc_valid_cycles++;
         if (bus.state == S_ENC) enc_state_cycles++;
         if (bus.vga_go) begin
            vga_q.push_back(bus.vga_char);
            if (go_gap < 2) gap_viol++;
            go_gap = 0;
         end else go_gap++;
         bus.res_valid = 1'b0;
         if (lat > 0) begin
            lat--;
            if (lat == 0) begin bus.res_valid = 1'b1; bus.res_char = res_hold; end
         end
         bus.enc_ready = dp_stall ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
         if (bus.enc_valid && bus.enc_ready) begin
            enc_q.push_back(bus.enc_char);
            res_hold = bus.enc_char + 8'd1;
            lat = 2;
         end
         if (bus.vga_go) busy_cnt = 4;
         else if (busy_cnt > 0) busy_cnt--;
         bus.vga_busy = vga_hold || (busy_cnt > 0);
      end
   end

   // Reference: nonzero keystrokes fill the buffer up to DEPTH, extras set overflow.
   function automatic void build_model();
      int nz = 0;
      exp_buf.delete();
      foreach (stim_q[i]) begin
         if (stim_q[i] != 8'h00) begin
            nz++;
            if (exp_buf.size() < DEPTH) exp_buf.push_back(stim_q[i]);
         end
      end
      exp_ovf = (nz > DEPTH);
   endfunction

   function automatic int enc_diff();
      if (enc_q.size() != exp_buf.size()) return (enc_q.size() < exp_buf.size()) ? enc_q.size() : exp_buf.size();
      foreach (exp_buf[i]) if (enc_q[i] !== exp_buf[i]) return i;
      return -1;
   endfunction

   function automatic int vga_diff();
      logic [7:0] e;
      if (vga_q.size() != exp_buf.size()) return (vga_q.size() < exp_buf.size()) ? vga_q.size() : exp_buf.size();
      foreach (exp_buf[i]) begin
         e = exp_buf[i] + 8'd1;
         if (vga_q[i] !== e) return i;
      end
      return -1;
   endfunction

   task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (bus.state == s) begin ok = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   task automatic press_enter();
      bus.enter_n = 1'b0;
      repeat (4) @(negedge clk);
      bus.enter_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic type_char(input logic [7:0] c);
      bus.kb_ready = 1'b1; bus.kb_ascii = c;
      @(negedge clk);
      bus.kb_ready = 1'b0; bus.kb_ascii = 8'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
   endtask

   task automatic start_msg(input logic [7:0] key, output bit ok);
      bit w;
      ok = 1'b1;
      if (bus.state == S_DONE) begin press_enter(); wait_state(S_IDLE, 20, w); ok &= w; end
      clr_id++;
      press_enter(); wait_state(S_KEY, 20, w); ok &= w;
      type_char(key); wait_state(S_MSG, 20, w); ok &= w;
   endtask

   task automatic test_reset();
      resetn = 1'b0; bus.enter_n = 1'b1; bus.kb_ready = 1'b0; bus.kb_ascii = 8'h00;
      repeat (3) @(negedge clk);
      n_vec++; if (bus.state !== S_IDLE) begin n_err++; $display("FAIL rst_state: got %0d want 0", bus.state); end
      n_vec++; if (bus.count !== '0) begin n_err++; $display("FAIL rst_count: got %0d want 0", bus.count); end
      n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow: got %b want 0", bus.overflow); end
      n_vec++; if (bus.key_load !== 1'b0) begin n_err++; $display("FAIL rst_key_load: got %b want 0", bus.key_load); end
      n_vec++; if (bus.key_char !== 8'h00) begin n_err++; $display("FAIL rst_key_char: got %h want 00", bus.key_char); end
      n_vec++; if (bus.enc_valid !== 1'b0) begin n_err++; $display("FAIL rst_enc_valid: got %b want 0", bus.enc_valid); end
      n_vec++; if (bus.enc_char !== 8'h00) begin n_err++; $display("FAIL rst_enc_char: got %h want 00", bus.enc_char); end
      n_vec++; if (bus.vga_go !== 1'b0) begin n_err++; $display("FAIL rst_vga_go: got %b want 0", bus.vga_go); end
      n_vec++; if (bus.vga_char !== 8'h00) begin n_err++; $display("FAIL rst_vga_char: got %h want 00", bus.vga_char); end
      resetn = 1'b1;
      repeat (3) @(negedge clk);
      n_vec++; if (bus.state !== S_IDLE) begin n_err++; $display("FAIL post_rst_state: got %0d want 0", bus.state); end
   endtask

   task automatic test_basic();
      bit ok, w;
      int d;
      stim_q = '{8'h41, 8'h42, 8'h43};
      build_model();
      start_msg(8'h4B, ok);
      foreach (stim_q[i]) type_char(stim_q[i]);
      press_enter(); wait_state(S_DONE, 2000, w); ok &= w;
      n_vec++; if (!ok) begin n_err++; $display("FAIL basic_flow: state %0d, required to reach 5", bus.state); end
      n_vec++; if (key_q.size() != 1 || key_q[0] !== 8'h4B) begin n_err++; $display("FAIL basic_key_load: %0d pulses, first %h, want 1 pulse of 4b", key_q.size(), key_q[0]); end
      n_vec++; if (bus.count !== 5'd3) begin n_err++; $display("FAIL basic_count: got %0d want 3", bus.count); end
      d = enc_diff();
      n_vec++; if (d != -1) begin n_err++; $display("FAIL basic_enc: diff at %0d, got %0d chars, want %0d", d, enc_q.size(), exp_buf.size()); end
      d = vga_diff();
      n_vec++; if (d != -1) begin n_err++; $display("FAIL basic_vga: diff at %0d, got %0d chars, want %0d", d, vga_q.size(), exp_buf.size()); end
      n_vec++; if (gap_viol != 0) begin n_err++; $display("FAIL basic_vga_spacing: %0d close pulses, want 0", gap_viol); end
   endtask

   task automatic test_overflow();
      bit ok, w;
      int d;
      stim_q.delete();
      for (int k = 0; k < DEPTH + 2; k++) stim_q.push_back(8'($urandom_range(1, 255)));
      build_model();
      start_msg(8'($urandom_range(1, 255)), ok);
      foreach (stim_q[i]) type_char(stim_q[i]);
      press_enter(); wait_state(S_DONE, 4000, w); ok &= w;
      n_vec++; if (!ok) begin n_err++; $display("FAIL ovf_flow: state %0d, required to reach 5", bus.state); end
      n_vec++; if (bus.count !== (AW+1)'(exp_buf.size())) begin n_err++; $display("FAIL ovf_count: got %0d want %0d", bus.count, exp_buf.size()); end
      n_vec++; if (bus.overflow !== exp_ovf) begin n_err++; $display("FAIL ovf_flag: got %b want %b", bus.overflow, exp_ovf); end
      d = enc_diff();
      n_vec++; if (d != -1) begin n_err++; $display("FAIL ovf_enc: diff at %0d, got %0d chars, want %0d", d, enc_q.size(), exp_buf.size()); end
      d = vga_diff();
      n_vec++; if (d != -1) begin n_err++; $display("FAIL ovf_vga: diff at %0d, got %0d chars, want %0d", d, vga_q.size(), exp_buf.size()); end
      press_enter(); wait_state(S_IDLE, 20, w);
      n_vec++; if (!w || bus.count !== '0 || bus.overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: state %0d count %0d overflow %b, want 0/0/0", bus.state, bus.count, bus.overflow); end
   endtask

   task automatic test_empty();
      bit ok, w;
      start_msg(8'h55, ok);
      press_enter(); wait_state(S_DONE, 40, w); ok &= w;
      n_vec++; if (!ok) begin n_err++; $display("FAIL empty_flow: state %0d, required to reach 5", bus.state); end
      n_vec++; if (enc_valid_cycles != 0 || enc_state_cycles != 0) begin n_err++; $display("FAIL empty_enc: enc_valid %0d cycles, ENC %0d cycles, want 0/0", enc_valid_cycles, enc_state_cycles); end
      n_vec++; if (vga_q.size() != 0) begin n_err++; $display("FAIL empty_vga: got %0d pulses want 0", vga_q.size()); end
      type_char(8'h61);
      repeat (3) @(negedge clk);
      n_vec++; if (bus.count !== '0 || bus.state !== S_DONE) begin n_err++; $display("FAIL done_ignores_key: count %0d state %0d, want 0/5", bus.count, bus.state); end
   endtask

   task automatic test_simultaneous();
      bit ok, w;
      int d;
      stim_q = '{8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 8'h00, 8'h5A};
      build_model();
      start_msg(8'($urandom_range(1, 255)), ok);
      type_char(stim_q[0]); type_char(stim_q[1]); type_char(stim_q[2]);
      repeat (3) @(negedge clk);
      n_vec++; if (bus.count !== 5'd2) begin n_err++; $display("FAIL zero_tick_filter: count %0d want 2", bus.count); end
      // Enter sampled at edge N and 'Z' sampled at N+2 both act on edge N+3.
      bus.enter_n = 1'b0;
      @(negedge clk); @(negedge clk);
      bus.kb_ready = 1'b1; bus.kb_ascii = 8'h5A;
      @(negedge clk);
      bus.kb_ready = 1'b0; bus.kb_ascii = 8'h00;
      repeat (3) @(negedge clk);
      bus.enter_n = 1'b1;
      wait_state(S_DONE, 2000, w); ok &= w;
      n_vec++; if (!ok) begin n_err++; $display("FAIL simul_flow: state %0d, required to reach 5", bus.state); end
      n_vec++; if (bus.count !== 5'd3) begin n_err++; $display("FAIL simul_count: got %0d want 3", bus.count); end
      d = enc_diff();
      n_vec++; if (d != -1) begin n_err++; $display("FAIL simul_enc: diff at %0d, got %0d chars, want %0d", d, enc_q.size(), exp_buf.size()); end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_backpressure();
      bit ok, w;
      int d;
      stim_q = '{8'($urandom_range(1, 255)), 8'($urandom_range(1, 255))};
      build_model();
      dp_stall = 1'b1; vga_hold = 1'b1;
      start_msg(8'($urandom_range(1, 255)), ok);
      foreach (stim_q[i]) type_char(stim_q[i]);
      press_enter();
      w = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (bus.enc_valid) begin w = 1'b1; break; end
         @(negedge clk);
      end
      n_vec++; if (!(ok && w)) begin n_err++; $display("FAIL bp_valid_rise: enc_valid %b, want 1", bus.enc_valid); end
      for (int i = 0; i < 10; i++) begin
         n_vec++; if (bus.enc_valid !== 1'b1 || bus.enc_char !== exp_buf[0]) begin n_err++; $display("FAIL bp_hold cycle %0d: valid %b char %h, want 1 %h", i, bus.enc_valid, bus.enc_char, exp_buf[0]); end
         @(negedge clk);
      end
      dp_stall = 1'b0;
      wait_state(S_SHOW, 500, w);
      repeat (10) @(negedge clk);
      n_vec++; if (!w || vga_q.size() != 0) begin n_err++; $display("FAIL bp_vga_busy: reached SHOW %b, %0d pulses, want 1 and 0", w, vga_q.size()); end
      vga_hold = 1'b0;
      wait_state(S_DONE, 2000, w);
      d = vga_diff();
      n_vec++; if (!w || d != -1) begin n_err++; $display("FAIL bp_vga: done %b diff at %0d, got %0d chars, want %0d", w, d, vga_q.size(), exp_buf.size()); end
   endtask

   task automatic test_reset_mid_enc();
      bit ok, w;
      int d;
      logic [7:0] key;
      stim_q = '{8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255))};
      dp_stall = 1'b1;
      start_msg(8'($urandom_range(1, 255)), ok);
      foreach (stim_q[i]) type_char(stim_q[i]);
      press_enter();
      wait_state(S_ENC, 20, w);
      repeat (3) @(negedge clk);
      n_vec++; if (!(ok && w && bus.enc_valid)) begin n_err++; $display("FAIL rmid_setup: state %0d enc_valid %b, want 3 and 1", bus.state, bus.enc_valid); end
      #2 resetn = 1'b0;
      #1;
      n_vec++;
      if ({bus.state, bus.count, bus.overflow, bus.key_load, bus.key_char, bus.enc_valid, bus.enc_char, bus.vga_go, bus.vga_char} !== 36'h0) begin
         n_err++;
         $display("FAIL rmid_outputs: got %h want 000000000",
                  {bus.state, bus.count, bus.overflow, bus.key_load, bus.key_char, bus.enc_valid, bus.enc_char, bus.vga_go, bus.vga_char});
      end
      @(negedge clk);
      resetn = 1'b1; dp_stall = 1'b0;
      repeat (2) @(negedge clk);
      key = 8'($urandom_range(1, 255));
      stim_q = '{8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255))};
      build_model();
      start_msg(key, ok);
      foreach (stim_q[i]) type_char(stim_q[i]);
      press_enter(); wait_state(S_DONE, 2000, w); ok &= w;
      d = vga_diff();
      n_vec++; if (!ok || d != -1 || enc_diff() != -1 || bus.key_char !== key) begin n_err++; $display("FAIL rmid_recover: done %b vga diff %0d enc diff %0d key %h want %h", ok, d, enc_diff(), bus.key_char, key); end
   endtask

   task automatic test_random();
      bit ok, w;
      int d, n;
      logic [7:0] key;
      rand_ready = 1'b1;
      for (int r = 0; r < 4; r++) begin
         key = 8'($urandom_range(1, 255));
         n = $urandom_range(0, 20);
         stim_q.delete();
         for (int k = 0; k < n; k++) stim_q.push_back(($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
         build_model();
         start_msg(key, ok);
         foreach (stim_q[i]) type_char(stim_q[i]);
         press_enter(); wait_state(S_DONE, 4000, w); ok &= w;
         n_vec++; if (!ok) begin n_err++; $display("FAIL rnd%0d_flow: state %0d, required to reach 5", r, bus.state); end
         n_vec++; if (key_q.size() != 1 || key_q[0] !== key) begin n_err++; $display("FAIL rnd%0d_key: %0d pulses, first %h, want 1 of %h", r, key_q.size(), key_q[0], key); end
         n_vec++; if (bus.count !== (AW+1)'(exp_buf.size()) || bus.overflow !== exp_ovf) begin n_err++; $display("FAIL rnd%0d_count: count %0d ovf %b, want %0d %b", r, bus.count, bus.overflow, exp_buf.size(), exp_ovf); end
         d = enc_diff();
         n_vec++; if (d != -1) begin n_err++; $display("FAIL rnd%0d_enc: diff at %0d, got %0d chars, want %0d", r, d, enc_q.size(), exp_buf.size()); end
         d = vga_diff();
         n_vec++; if (d != -1 || gap_viol != 0) begin n_err++; $display("FAIL rnd%0d_vga: diff at %0d, %0d close pulses, got %0d chars, want %0d", r, d, gap_viol, vga_q.size(), exp_buf.size()); end
      end
      rand_ready = 1'b0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.enter_n = 1'b1; bus.kb_ready = 1'b0; bus.kb_ascii = 8'h00;
      test_reset();
      test_basic();
      test_overflow();
      test_empty();
      test_simultaneous();
      test_backpressure();
      test_reset_mid_enc();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/cipher_sequencer.md
# cipher_sequencer

Top-level controller for the keyboard cipher pipeline. It replaces the toggle-based keystroke clock with a single-clock sequencer that:
- accepts ASCII keystrokes from the scan-code-to-ASCII decoder and captures the cipher key;
- buffers the plaintext message;
- streams each character through the cipher datapath with a valid/ready handshake;
- writes the results back in place, then issues one display request per character to the VGA writer.

## Interface

- DEPTH, 16, message buffer entries; power of two, 2..256
- AW, 4, log2(DEPTH); count width is AW+1

- clk  in  1  system clock (CLOCK_50)
- resetn  in  1  asynchronous, active-low reset
- kb_ready  in  1  one-cycle keystroke tick, synchronous to clk
- kb_ascii  in  8  ASCII of the current keystroke; 8'h00 means unmapped
- enter_n  in  1  enter pushbutton, active-low, asynchronous to clk
- key_load  out  1  one-cycle pulse: datapath latches key_char as the cipher key
- key_char  out  8  cipher key character
- enc_valid  out  1  plaintext character offered to the datapath
- enc_char  out  8  plaintext character
- enc_ready  in  1  datapath accepts enc_char this cycle
- res_valid  in  1  datapath result valid (one cycle)
- res_char  in  8  ciphertext character
- vga_go  out  1  one-cycle display request
- vga_char  out  8  character to display
- vga_busy  in  1  VGA writer busy; rises within 1 cycle of vga_go
- state  out  3  current top state (drives LEDR)
- count  out  AW+1  characters stored in the buffer
- overflow  out  1  sticky: a keystroke was dropped because the buffer was full

## Operation

- Keystroke event: kb_ready=1 and kb_ascii!=0. It is ignored outside KEY and MSG.
- enter_n handling: 2-flop synchronizer, then falling-edge detect. This produces enter_evt, one cycle per press.
- Top states and encoding:
  - IDLE=0 -> KEY on enter_evt.
  - KEY=1 -> on the first keystroke event: key_char<=kb_ascii, key_load pulses one cycle, go to MSG. enter_evt is ignored in KEY.
  - MSG=2 -> on a keystroke event:
    - count<DEPTH: buf[count]<=kb_ascii, count++.
    - count==DEPTH: character dropped, overflow<=1.
    - On enter_evt: go to ENC if count>0, else DONE.
    - Keystroke and enter_evt in the same cycle: the character is stored first (subject to the full rule), then the transition is taken using the updated count.
  - ENC=3 -> index i runs 0..count-1 through substates:
    - ISSUE: enc_valid=1, enc_char=buf[i]. Hold until enc_ready, then go to WAIT.
    - WAIT: on res_valid, buf[i]<=res_char. If i==count-1, go to SHOW with i<=0; else i++ and go to ISSUE.
    - A res_valid seen in ISSUE is ignored.
  - SHOW=4 -> index i runs 0..count-1 through substates:
    - GO: when vga_busy=0, vga_go=1 for one cycle with vga_char=buf[i].
    - HOLD: one cycle.
    - IDLEWAIT: when vga_busy=0, either i++ and go to GO, or go to DONE after the last character.
  - DONE=5 -> IDLE on enter_evt. Entering IDLE clears count and overflow. key_char is retained.
- Buffer contents are not reset; only count defines validity.

## Timing

- Reset values: state=IDLE, count=0, overflow=0, key_load=0, key_char=8'h00, enc_valid=0, enc_char=8'h00, vga_go=0, vga_char=8'h00. All substates and indices are 0.
- resetn assertion mid-operation: everything returns immediately (asynchronously) to the reset values. Any in-flight datapath or VGA transaction is abandoned.
- All outputs are registered.
- kb_ready latency: a tick at edge N gives buffer write and count update visible after edge N+1.
- enter_n latency: a falling edge sampled at edge N gives enter_evt at N+2 and the state change visible after N+3.
- enc_valid rises the cycle after entering ENC and stays high until the enc_ready handshake cycle. It is low the following cycle.
- Per-character ENC cost: 1 (issue) + handshake wait + datapath latency + 1.
- vga_go never asserts on consecutive cycles. There are at least 2 cycles between pulses.

## Test plan

- Basic flow: reset; enter; key 'K'(8'h4B); type 'A','B','C'; enter. A datapath model returns char+1 with 2-cycle latency; VGA model busy for 4 cycles.
  - Required: one key_load with 8'h4B, count=3, three enc handshakes with 41,42,43.
  - Required: vga_go×3 with 42,43,44; state ends at 5.
- Overflow: DEPTH=16, type 18 characters in MSG -> count=16, overflow=1, first 16 characters buffered, 17th/18th absent from the enc stream. Enter in DONE -> count=0, overflow=0.
- Empty message: enter in MSG with count=0 -> ENC skipped, state goes 2→5, no enc_valid and no vga_go.
- Simultaneous events and filtering: keystroke 'Z' and enter_evt in the same MSG cycle -> 'Z' stored, count increments, state goes to ENC. kb_ascii=00 ticks -> no write.
- Backpressure: hold enc_ready=0 for 10 cycles -> enc_valid and enc_char stable throughout. Hold vga_busy=1 -> no vga_go issued.
- Reset mid-ENC: assert resetn=0 while enc_valid=1 -> all outputs at reset values within the same cycle; a clean full flow completes after release.
